// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S audio port.
// Slot encoding matches the LRCLK level: low = left, high = right.
package i2s_pkg;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_SLOT_W   = 32;
    localparam int MIN_SCLK_DIV = 8;

    function automatic int cnt_width(input int slot_w);
        return $clog2(slot_w + 1);
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings the codec's SCLK/LRCLK/DIN into the system domain and turns SCLK
// edges into single-cycle strobes, with LRCLK/DIN aligned to those strobes.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk,
    input  logic lrclk,
    input  logic din,
    output logic lrclk_sync,
    output logic din_sync,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] lrclk_pipe;
    logic [SYNC_STAGES-1:0] din_pipe;
    logic                   sclk_prev;

    // The strobes are registered, so LRCLK/DIN get one matching extra flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_pipe  <= '0;
            lrclk_pipe <= '0;
            din_pipe   <= '0;
            sclk_prev  <= 1'b0;
            sclk_rise  <= 1'b0;
            sclk_fall  <= 1'b0;
            lrclk_sync <= 1'b0;
            din_sync   <= 1'b0;
        end else begin
            sclk_pipe  <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            lrclk_pipe <= {lrclk_pipe[SYNC_STAGES-2:0], lrclk};
            din_pipe   <= {din_pipe[SYNC_STAGES-2:0], din};
            sclk_prev  <= sclk_pipe[SYNC_STAGES-1];
            sclk_rise  <= sclk_pipe[SYNC_STAGES-1] & ~sclk_prev;
            sclk_fall  <= ~sclk_pipe[SYNC_STAGES-1] & sclk_prev;
            lrclk_sync <= lrclk_pipe[SYNC_STAGES-1];
            din_sync   <= din_pipe[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_audio_port.sv
// I2S slave engine: codec drives SCLK/LRCLK; receives L/R samples and
// transmits a held L/R pair (software-supplied or looped back) MSB first.
//   slot       | meaning
//   SLOT_LEFT  | LRCLK low, left sample shifting in/out
//   SLOT_RIGHT | LRCLK high, right sample shifting in/out
module i2s_audio_port
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int SLOT_W      = DEF_SLOT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i2s_sclk,
    input  logic                i2s_lrclk,
    input  logic                i2s_din,
    output logic                i2s_dout,
    input  logic                loopback,
    input  logic [SAMPLE_W-1:0] tx_left,
    input  logic [SAMPLE_W-1:0] tx_right,
    output logic                tx_ready,
    output logic [SAMPLE_W-1:0] rx_left,
    output logic [SAMPLE_W-1:0] rx_right,
    output logic                rx_valid,
    output logic                locked,
    output logic                frame_err,
    input  logic                err_clr
);

    localparam int               CNT_W      = cnt_width(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic lrclk_s;
    logic din_s;
    logic sclk_rise;
    logic sclk_fall;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (i2s_sclk),
        .lrclk     (i2s_lrclk),
        .din       (i2s_din),
        .lrclk_sync(lrclk_s),
        .din_sync  (din_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    slot_e               slot_q;
    slot_e               slot_s;
    slot_e               slot_d;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    cnt_d;
    logic                new_slot;
    logic                left_start;
    logic                capture;
    logic                publish;
    logic                pub_pending;
    logic                err_set;
    logic                tx_bit;
    logic [SAMPLE_W-1:0] shift_left;
    logic [SAMPLE_W-1:0] shift_right;
    logic [SAMPLE_W-1:0] hold_left;
    logic [SAMPLE_W-1:0] hold_right;
    logic [SAMPLE_W-1:0] tx_word;
    logic [SAMPLE_W-1:0] tx_shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= SLOT_LEFT;
            bit_cnt <= '0;
        end else begin
            slot_q  <= slot_d;
            bit_cnt <= cnt_d;
        end
    end

    always_comb begin
        slot_s     = slot_e'(lrclk_s);
        new_slot   = (slot_s != slot_q);
        cnt_next   = bit_cnt;
        slot_d     = slot_q;
        cnt_d      = bit_cnt;
        if (new_slot) begin
            cnt_next = '0;
        end else if (bit_cnt != CNT_MAX) begin
            cnt_next = bit_cnt + CNT_ONE;
        end
        if (sclk_rise) begin
            slot_d = slot_s;
            cnt_d  = cnt_next;
        end
        left_start = sclk_rise && new_slot && (slot_s == SLOT_LEFT);
        capture    = sclk_rise && (cnt_next >= CNT_ONE) && (cnt_next <= SAMPLE_CNT);
        publish    = capture && (slot_s == SLOT_RIGHT) && (cnt_next == SAMPLE_CNT) && locked;
        // Flag only the transition into saturation so err_clr can stick
        // even while the slot overrun continues.
        err_set    = sclk_rise && (cnt_next == CNT_MAX) && (bit_cnt != CNT_MAX);
    end

    always_comb begin
        tx_word    = (slot_q == SLOT_LEFT) ? hold_left : hold_right;
        tx_shifted = tx_word << bit_cnt;
        tx_bit     = 1'b0;
        if (locked && (bit_cnt < SAMPLE_CNT)) begin
            tx_bit = tx_shifted[SAMPLE_W-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked      <= 1'b0;
            tx_ready    <= 1'b0;
            rx_valid    <= 1'b0;
            pub_pending <= 1'b0;
            rx_left     <= '0;
            rx_right    <= '0;
            shift_left  <= '0;
            shift_right <= '0;
            hold_left   <= '0;
            hold_right  <= '0;
            i2s_dout    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            tx_ready    <= left_start;
            pub_pending <= publish;
            rx_valid    <= pub_pending;
            if (pub_pending) begin
                rx_left  <= shift_left;
                rx_right <= shift_right;
            end
            if (left_start) begin
                locked     <= 1'b1;
                hold_left  <= loopback ? rx_left  : tx_left;
                hold_right <= loopback ? rx_right : tx_right;
            end
            if (capture) begin
                if (slot_s == SLOT_LEFT) begin
                    shift_left <= {shift_left[SAMPLE_W-2:0], din_s};
                end else begin
                    shift_right <= {shift_right[SAMPLE_W-2:0], din_s};
                end
            end
            if (sclk_fall) begin
                i2s_dout <= tx_bit;
            end
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
